// File: rtl/risc_core_pkg.sv
// Shared opcode and FSM state encodings for the accumulator core.
package risc_core_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF0  = 3'd1,
    S_IF1  = 3'd2,
    S_EX   = 3'd3,
    S_MRD  = 3'd4,
    S_MWR  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam int OPCODE_W = 3;

endpackage

// File: rtl/risc_alu.sv
// Combinational accumulator ALU: ADD/AND/XOR, LDA passes memory data, others keep acc.
module risc_alu
  import risc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_LDA:  result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/risc_core.sv
// Multi-cycle accumulator RISC core with split read/write buses and resumable HLT.
// Define RISC_CORE_WAIT_EN to honour mem_ready wait states; otherwise every access is one cycle.
module risc_core
  import risc_core_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 13,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              halt,
  output logic              fetch,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [DATA_W-1:0] acc
);

  localparam int IR_W = 2 * DATA_W;

  state_t            state, state_nxt;
  logic [IR_W-1:0]   ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] alu_res;
  logic              ready;
  opcode_t           op;

`ifdef RISC_CORE_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
  assign ready        = 1'b1;
`endif

  // Middle IR bits between opcode and address field are don't-care.
  logic unused_ir;
  assign unused_ir = ^ir;

  assign op        = opcode_t'(ir[IR_W-1 -: OPCODE_W]);
  assign opcode    = ir[IR_W-1 -: OPCODE_W];
  assign ir_addr   = ir[ADDR_W-1:0];
  assign pc_addr   = pc;
  assign mem_wdata = acc;

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (acc),
    .b      (mem_rdata),
    .result (alu_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    fetch     = 1'b0;
    halt      = 1'b0;
    mem_addr  = pc;
    case (state)
      S_RST: state_nxt = S_IF0;
      S_IF0: begin
        mem_rd = 1'b1;
        fetch  = 1'b1;
        if (ready) state_nxt = S_IF1;
      end
      S_IF1: begin
        mem_rd = 1'b1;
        fetch  = 1'b1;
        if (ready) state_nxt = S_EX;
      end
      S_EX: begin
        case (op)
          OP_HLT:         state_nxt = S_HALT;
          OP_SKZ, OP_JMP: state_nxt = S_IF0;
          OP_STO:         state_nxt = S_MWR;
          default:        state_nxt = S_MRD;
        endcase
      end
      S_MRD: begin
        mem_rd   = 1'b1;
        mem_addr = ir_addr;
        if (ready) state_nxt = S_IF0;
      end
      S_MWR: begin
        mem_wr   = 1'b1;
        mem_addr = ir_addr;
        if (ready) state_nxt = S_IF0;
      end
      S_HALT: begin
        halt = 1'b1;
        if (resume) state_nxt = S_IF0;
      end
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= ADDR_W'(RESET_PC);
      acc <= '0;
      ir  <= '0;
    end else begin
      case (state)
        S_IF0: if (ready) begin
          ir[IR_W-1 -: DATA_W] <= mem_rdata;
          pc                   <= pc + ADDR_W'(1);
        end
        S_IF1: if (ready) begin
          ir[DATA_W-1:0] <= mem_rdata;
          pc             <= pc + ADDR_W'(1);
        end
        S_EX: begin
          // SKZ tests the accumulator as it stands at execute.
          if (op == OP_SKZ && acc == '0) pc <= pc + ADDR_W'(2);
          else if (op == OP_JMP)         pc <= ir_addr;
        end
        S_MRD: if (ready) acc <= alu_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_core.sv
// Directed bench for risc_core: memory model, fetch log and assertion-based checks.
module tb_risc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd, mem_wr, halt, fetch;
  logic [12:0] mem_addr, ir_addr, pc_addr;
  logic [7:0]  mem_wdata, mem_rdata, acc;
  logic [2:0]  opcode;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;
  logic        done;

  logic [7:0]  mem [0:8191];
  logic [12:0] flog [$];
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  int          wr_cnt, cycles, wait_n, cnt, stab_err;
  int          passed = 0, total = 0;
  logic        prev_pend, prev_rd, prev_wr;
  logic [12:0] prev_addr;
  logic [7:0]  prev_wdata;

  risc_core dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .resume(resume), .halt(halt), .fetch(fetch),
    .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr), .acc(acc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
`ifdef RISC_CORE_WAIT_EN
  assign done = mem_ready;
`else
  assign done = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: record what completes on the coming edge, then advance to the next negedge.
  task automatic cyc();
    if (!reset) begin
      if (fetch && done) flog.push_back(mem_addr);
      if (mem_wr && done) begin
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        wr_cnt++;
      end
      prev_pend  = (mem_rd || mem_wr) && !done;
      prev_rd    = mem_rd;
      prev_wr    = mem_wr;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if ((mem_rd || mem_wr) && done) cnt = 0;
      else if (mem_rd || mem_wr)      cnt++;
    end
    @(negedge clk);
    cycles++;
    if (prev_pend && (mem_rd !== prev_rd || mem_wr !== prev_wr ||
                      mem_addr !== prev_addr || (mem_wr && mem_wdata !== prev_wdata)))
      stab_err++;
    mem_ready = (mem_rd || mem_wr) && (cnt == wait_n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    cnt = 0;
    prev_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    flog.delete();
    wr_cnt = 0;
    cycles = 0;
    stab_err = 0;
    mem_ready = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    while (!halt && cycles < 500) cyc();
    chk(tag, 32'(halt), 32'd1);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  task automatic load_sum();
    clr_mem();
    mem[0] = 8'hA1; mem[1] = 8'h00;   // LDA 0x100
    mem[2] = 8'h41; mem[3] = 8'h01;   // ADD 0x101
    mem[4] = 8'hC1; mem[5] = 8'h02;   // STO 0x102
    mem[6] = 8'h00; mem[7] = 8'h00;   // HLT
    mem[13'h100] = 8'h05;
    mem[13'h101] = 8'h03;
  endtask

  initial begin
    wait_n = 0;
    clr_mem();
    // Reset state while reset is held
    #2;
    chk("rst_rd",    32'(mem_rd), 32'd0);
    chk("rst_wr",    32'(mem_wr), 32'd0);
    chk("rst_halt",  32'(halt), 32'd0);
    chk("rst_fetch", 32'(fetch), 32'd0);
    chk("rst_pc",    32'(pc_addr), 32'd0);
    chk("rst_acc",   32'(acc), 32'd0);

    // 1: LDA/ADD/STO program
    load_sum();
    do_reset();
    cyc();
    chk("t1_if0_fetch", 32'(fetch), 32'd1);
    chk("t1_if0_addr",  32'(mem_addr), 32'd0);
    run_to_halt("t1_halt");
    chk("t1_cycles",  32'(cycles), 32'd16);
    chk("t1_wr_cnt",  32'(wr_cnt), 32'd1);
    chk("t1_wr_addr", 32'(wr_addr), 32'h102);
    chk("t1_wr_data", 32'(wr_data), 32'h08);
    chk("t1_acc",     32'(acc), 32'h08);
    chk("t1_pc",      32'(pc_addr), 32'h008);

    // 2a: SKZ taken with acc==0, JMP skipped
    clr_mem();
    mem[0] = 8'hA1; mem[1] = 8'h00;   // LDA 0x100 (=0)
    mem[2] = 8'h20; mem[3] = 8'h00;   // SKZ
    mem[4] = 8'hE0; mem[5] = 8'h50;   // JMP 0x050
    mem[6] = 8'h00; mem[7] = 8'h00;   // HLT
    mem[13'h050] = 8'h00; mem[13'h051] = 8'h00;
    do_reset();
    run_to_halt("t2a_halt");
    chk("t2a_pc",     32'(pc_addr), 32'h008);
    chk("t2a_cycles", 32'(cycles), 32'd11);
    chk("t2a_nfetch", 32'(flog.size()), 32'd6);
    if (flog.size() == 6) chk("t2a_skip_to", 32'(flog[4]), 32'h006);

    // 2b: acc!=0, SKZ falls through and JMP lands at 0x050
    mem[13'h100] = 8'h07;
    do_reset();
    run_to_halt("t2b_halt");
    chk("t2b_pc",  32'(pc_addr), 32'h052);
    chk("t2b_acc", 32'(acc), 32'h07);

    // 3: three wait states on every access
    load_sum();
    wait_n = 3;
    do_reset();
    run_to_halt("t3_halt");
`ifdef RISC_CORE_WAIT_EN
    chk("t3_cycles", 32'(cycles), 32'd49);
`else
    chk("t3_cycles", 32'(cycles), 32'd16);
`endif
    chk("t3_stable", 32'(stab_err), 32'd0);
    chk("t3_acc",    32'(acc), 32'h08);
    chk("t3_wr",     32'(wr_data), 32'h08);
    wait_n = 0;

    // 4: halt hold, then resume continues after HLT
    clr_mem();
    mem[0] = 8'hE0; mem[1] = 8'h10;                 // JMP 0x010
    mem[13'h010] = 8'h00; mem[13'h011] = 8'h00;     // HLT
    mem[13'h012] = 8'hA1; mem[13'h013] = 8'h00;     // LDA 0x100
    mem[13'h014] = 8'h00; mem[13'h015] = 8'h00;     // HLT
    mem[13'h100] = 8'h5A;
    do_reset();
    run_to_halt("t4_halt1");
    chk("t4_pc_halt", 32'(pc_addr), 32'h012);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_hold", {29'd0, halt, mem_rd, mem_wr}, 32'b100);
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t4_res_fetch", 32'(fetch), 32'd1);
    chk("t4_res_addr",  32'(mem_addr), 32'h012);
    run_to_halt("t4_halt2");
    chk("t4_acc", 32'(acc), 32'h5A);
    chk("t4_pc",  32'(pc_addr), 32'h016);

    // 5: HLT split across top of memory and address 0
    clr_mem();
    mem[0] = 8'hFF; mem[1] = 8'hFF;   // JMP 0x1FFF; mem[0] doubles as the HLT low byte
    do_reset();
    run_to_halt("t5_halt");
    chk("t5_nfetch", 32'(flog.size()), 32'd4);
    if (flog.size() == 4) begin
      chk("t5_fa_top",  32'(flog[2]), 32'h1FFF);
      chk("t5_fa_wrap", 32'(flog[3]), 32'h0000);
    end
    chk("t5_pc", 32'(pc_addr), 32'h0001);

    // 6: reset in the middle of a store
    load_sum();
    wait_n = 3;
    do_reset();
    while (!mem_wr && cycles < 200) cyc();
    chk("t6_in_mwr", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_wr_drop", 32'(mem_wr), 32'd0);
    chk("t6_pc",      32'(pc_addr), 32'd0);
    chk("t6_acc",     32'(acc), 32'd0);
    chk("t6_fetch",   32'(fetch), 32'd0);
    chk("t6_no_wr",   32'(wr_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    @(posedge clk);
    #1;
    chk("t6_restart_fetch", 32'(fetch), 32'd1);
    chk("t6_restart_addr",  32'(mem_addr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
